axis_consumer_mc: RTL and testbench

- Parametrised successor of the stream consumer/sink used for throughput measurement.
- Accepts a wide AXI-Stream input and separates two kinds of beats:
  - Marker beats carry AXI register requests. These are queued in a small request FIFO and emitted on a 72-bit request stream with full backpressure, so no request is dropped.
  - All other beats are data. They are counted into rows, an idle timeout, and a bytes-per-window throughput figure.

---
 rtl/axis_consumer_mc.sv | 175 +++++++++++++++++
 tb/tb_axis_consumer_mc.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_consumer_mc.sv
// Stream sink: splits marker beats into a request FIFO and counts data beats into rows and throughput windows.
// Define AXIS_CONSUMER_ROW_COUNT_EN to build the running row counter; otherwise row_count is tied to 0.
module axis_consumer_mc #(
    parameter int          DATA_WIDTH        = 512,
    parameter int          ROW_BEATS         = 34,
    parameter int          CYCLES_PER_WINDOW = 402832031,
    parameter int          IDLE_CYCLES       = 400000000,
    parameter logic [63:0] MARKER            = 64'hBEADCAFEFADEDBAD,
    parameter int          REQ_FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  row_complete,
    output logic [63:0]           throughput,
    output logic                  throughput_valid,
    output logic [31:0]           row_count,
    input  logic [DATA_WIDTH-1:0] AXIS_TDATA,
    input  logic                  AXIS_TVALID,
    output logic                  AXIS_TREADY,
    output logic [71:0]           AXI_REQ_TDATA,
    output logic                  AXI_REQ_TVALID,
    input  logic                  AXI_REQ_TREADY
);

    localparam int              RW         = $clog2(ROW_BEATS);
    localparam int              AW         = $clog2(REQ_FIFO_DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [RW-1:0]   LAST_ROW   = RW'(ROW_BEATS - 1);
    localparam logic [31:0]     LAST_CYCLE = 32'(CYCLES_PER_WINDOW - 1);
    localparam logic [31:0]     IDLE_LOAD  = 32'(IDLE_CYCLES);
    localparam logic [63:0]     BEAT_BYTES = 64'(DATA_WIDTH / 8);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(REQ_FIFO_DEPTH);

    logic [71:0]   fifo_mem_q [REQ_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [RW-1:0] row_q, row_d;
    logic [31:0]   idle_q, idle_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [63:0]   acc_q, acc_d;
    logic [63:0]   throughput_q, throughput_d;
    logic          tp_valid_q, tp_valid_d;
    logic          row_complete_q, row_complete_d;

    logic          is_marker, beat, push, pop, data_beat, req_valid;
    logic [RW-1:0] row_base;
    logic [63:0]   beat_bytes;
    logic [64:0]   acc_sum;
    logic [63:0]   acc_sat;
    logic          tdata_unused;

    assign tdata_unused = ^AXIS_TDATA;

    assign is_marker = (AXIS_TDATA[DATA_WIDTH-1 -: 64] == MARKER);
    assign beat      = AXIS_TVALID & AXIS_TREADY;
    assign push      = beat & is_marker;
    assign data_beat = beat & ~is_marker;

    assign AXIS_TREADY    = !reset && (count_q != FULL_COUNT);
    assign req_valid      = !reset && (count_q != '0);
    assign pop            = req_valid & AXI_REQ_TREADY;
    assign AXI_REQ_TVALID = req_valid;
    // Zero the head word when empty so the bus never shows a stale or uninitialised entry.
    assign AXI_REQ_TDATA  = req_valid ? fifo_mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // An expired idle countdown means the row restarts, even if a beat arrives this cycle.
    always_comb begin
        row_base       = (idle_q == '0) ? '0 : row_q;
        row_d          = row_q;
        row_complete_d = 1'b0;
        if (data_beat) begin
            if (row_base == LAST_ROW) begin
                row_d          = '0;
                row_complete_d = 1'b1;
            end else begin
                row_d = row_base + RW'(1);
            end
        end else if (idle_q == '0) begin
            row_d = '0;
        end

        if (data_beat)
            idle_d = IDLE_LOAD;
        else if (idle_q != '0)
            idle_d = idle_q - 32'd1;
        else
            idle_d = idle_q;
    end

    // The terminal-cycle beat is folded into the published figure so it is never lost.
    always_comb begin
        beat_bytes   = data_beat ? BEAT_BYTES : '0;
        acc_sum      = {1'b0, acc_q} + {1'b0, beat_bytes};
        acc_sat      = acc_sum[64] ? '1 : acc_sum[63:0];
        throughput_d = throughput_q;
        tp_valid_d   = 1'b0;
        if (cycle_q == LAST_CYCLE) begin
            cycle_d      = '0;
            acc_d        = '0;
            throughput_d = acc_sat;
            tp_valid_d   = 1'b1;
        end else begin
            cycle_d = cycle_q + 32'd1;
            acc_d   = acc_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q] <= AXIS_TDATA[71:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            row_q          <= '0;
            idle_q         <= '0;
            cycle_q        <= '0;
            acc_q          <= '0;
            throughput_q   <= '0;
            tp_valid_q     <= 1'b0;
            row_complete_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            row_q          <= row_d;
            idle_q         <= idle_d;
            cycle_q        <= cycle_d;
            acc_q          <= acc_d;
            throughput_q   <= throughput_d;
            tp_valid_q     <= tp_valid_d;
            row_complete_q <= row_complete_d;
        end
    end

    assign row_complete     = row_complete_q;
    assign throughput       = throughput_q;
    assign throughput_valid = tp_valid_q;

`ifdef AXIS_CONSUMER_ROW_COUNT_EN
    logic [31:0] row_count_q, row_count_d;

    always_comb begin
        row_count_d = row_complete_q ? row_count_q + 32'd1 : row_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            row_count_q <= '0;
        else
            row_count_q <= row_count_d;
    end

    assign row_count = row_count_q;
`else
    assign row_count = '0;
`endif

endmodule

// File: tb/tb_axis_consumer_mc.sv
// Scoreboard bench for axis_consumer_mc: rows, idle timeout, request FIFO backpressure, throughput windows, reset.
module tb_axis_consumer_mc;

    localparam int          DW    = 512;
    localparam int          RB    = 34;
    localparam int          CPW   = 100;
    localparam int          IDLE  = 20;
    localparam int          DEPTH = 4;
    localparam logic [63:0] MARK  = 64'hBEADCAFEFADEDBAD;

    logic          clk;
    logic          reset;
    logic          row_complete;
    logic [63:0]   throughput;
    logic          throughput_valid;
    logic [31:0]   row_count;
    logic [DW-1:0] AXIS_TDATA;
    logic          AXIS_TVALID;
    logic          AXIS_TREADY;
    logic [71:0]   AXI_REQ_TDATA;
    logic          AXI_REQ_TVALID;
    logic          AXI_REQ_TREADY;

    axis_consumer_mc #(
        .DATA_WIDTH       (DW),
        .ROW_BEATS        (RB),
        .CYCLES_PER_WINDOW(CPW),
        .IDLE_CYCLES      (IDLE),
        .MARKER           (MARK),
        .REQ_FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .row_complete    (row_complete),
        .throughput      (throughput),
        .throughput_valid(throughput_valid),
        .row_count       (row_count),
        .AXIS_TDATA      (AXIS_TDATA),
        .AXIS_TVALID     (AXIS_TVALID),
        .AXIS_TREADY     (AXIS_TREADY),
        .AXI_REQ_TDATA   (AXI_REQ_TDATA),
        .AXI_REQ_TVALID  (AXI_REQ_TVALID),
        .AXI_REQ_TREADY  (AXI_REQ_TREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          tb_cyc = 0;
    logic [71:0] req_q[$];
    int          row_q[$];
    logic [63:0] tp_q[$];
    int          exp_row_pos = 0;
    int          rows_since_reset = 0;
    bit          tp_chk = 1'b0;
    bit          row_ignore = 1'b0;
    int          last_tv = -1;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_row_count();
`ifdef AXIS_CONSUMER_ROW_COUNT_EN
        return 32'(rows_since_reset);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [DW-1:0] mk_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        v[DW-1 -: 64] = 64'h0;
        return v;
    endfunction

    function automatic logic [DW-1:0] mk_marker();
        logic [DW-1:0] v;
        v = mk_data();
        v[DW-1 -: 64] = MARK;
        v[71:64] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        return v;
    endfunction

    // Bench-side cycle index; stable when read on the falling edge.
    initial forever begin
        @(posedge clk);
        tb_cyc++;
    end

    // Drive one beat from posedge+1 and hold it until accepted; expectations are queued at acceptance.
    task automatic send_beat(input logic [DW-1:0] d);
        int waited = 0;
        bit done = 1'b0;
        AXIS_TDATA  = d;
        AXIS_TVALID = 1'b1;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (AXIS_TREADY) begin
                done = 1'b1;
                if (d[DW-1 -: 64] == MARK) begin
                    req_q.push_back(d[71:0]);
                end else if (exp_row_pos == RB - 1) begin
                    row_q.push_back(tb_cyc + 1);
                    exp_row_pos = 0;
                    rows_since_reset++;
                end else begin
                    exp_row_pos++;
                end
            end
            @(posedge clk);
            #1;
            waited++;
        end
        AXIS_TVALID = 1'b0;
        if (!done) check_eq("accept_timeout", 72'(done), 72'd1);
    endtask

    task automatic idle(input int n);
        AXIS_TVALID = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        @(posedge clk);
        #1;
        check_eq("rows_pending", 72'(row_q.size()), 72'd0);
    endtask

    task automatic wait_drain();
        int w = 0;
        while (req_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        check_eq("req_drain", 72'(req_q.size()), 72'd0);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_tready"},       72'(AXIS_TREADY),      72'd0);
        check_eq({pfx, "_req_valid"},    72'(AXI_REQ_TVALID),   72'd0);
        check_eq({pfx, "_req_data"},     AXI_REQ_TDATA,         72'd0);
        check_eq({pfx, "_row_complete"}, 72'(row_complete),     72'd0);
        check_eq({pfx, "_throughput"},   72'(throughput),       72'd0);
        check_eq({pfx, "_tp_valid"},     72'(throughput_valid), 72'd0);
        check_eq({pfx, "_row_count"},    72'(row_count),        72'd0);
    endtask

    // Output monitor: every DUT output transaction is matched against the head of its queue.
    initial forever begin
        logic [71:0] e_req;
        int          e_row;
        logic [63:0] e_tp;
        @(negedge clk);
        if (!reset) begin
            if (AXI_REQ_TVALID && AXI_REQ_TREADY) begin
                if (req_q.size() == 0) begin
                    check_eq("req_unexpected", 72'd1, 72'd0);
                end else begin
                    e_req = req_q.pop_front();
                    check_eq("req_word", AXI_REQ_TDATA, e_req);
                    $display("req  op=%02h addr=%08h data=%08h", AXI_REQ_TDATA[71:64],
                             AXI_REQ_TDATA[63:32], AXI_REQ_TDATA[31:0]);
                end
            end
            if (row_complete && !row_ignore) begin
                if (row_q.size() == 0) begin
                    check_eq("row_unexpected", 72'd1, 72'd0);
                end else begin
                    e_row = row_q.pop_front();
                    check_eq("row_cycle", 72'(tb_cyc), 72'(e_row));
                    $display("row  complete at cycle %0d", tb_cyc);
                end
            end
            if (throughput_valid) begin
                if (tp_chk) begin
                    if (tp_q.size() == 0) begin
                        check_eq("tp_unexpected", 72'd1, 72'd0);
                    end else begin
                        e_tp = tp_q.pop_front();
                        check_eq("throughput", 72'(throughput), 72'(e_tp));
                    end
                    if (last_tv >= 0) check_eq("tp_period", 72'(tb_cyc - last_tv), 72'(CPW));
                    $display("tp   %0d bytes at cycle %0d", throughput, tb_cyc);
                end
                last_tv = tb_cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] m[5];
        int  w;
        bit  seen;

        reset          = 1'b1;
        AXIS_TVALID    = 1'b0;
        AXIS_TDATA     = '0;
        AXI_REQ_TREADY = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two full rows back to back.
        repeat (2 * RB) send_beat(mk_data());
        settle();
        check_eq("t1_row_count", 72'(row_count), 72'(exp_row_count()));

        // Idle timeout clears a partial row; a gap one short of the timeout does not.
        repeat (10) send_beat(mk_data());
        idle(IDLE + 1);
        exp_row_pos = 0;
        repeat (RB) send_beat(mk_data());
        settle();
        repeat (10) send_beat(mk_data());
        idle(IDLE - 1);
        repeat (RB - 10) send_beat(mk_data());
        settle();
        check_eq("t2_row_count", 72'(row_count), 72'(exp_row_count()));

        // Five requests into a four-deep FIFO with the request side stalled.
        idle(IDLE + 2);
        exp_row_pos = 0;
        AXI_REQ_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) m[i] = mk_marker();
        for (int i = 0; i < 4; i++) send_beat(m[i]);
        AXIS_TDATA  = m[4];
        AXIS_TVALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("full_tready", 72'(AXIS_TREADY), 72'd0);
            check_eq("hold_valid", 72'(AXI_REQ_TVALID), 72'd1);
            check_eq("hold_data", AXI_REQ_TDATA, m[0][71:0]);
            @(posedge clk);
            #1;
        end
        AXI_REQ_TREADY = 1'b1;
        send_beat(m[4]);
        wait_drain();

        // Fill, then stream with the request side open so push and pop overlap near full.
        AXI_REQ_TREADY = 1'b0;
        repeat (DEPTH) send_beat(mk_marker());
        AXI_REQ_TREADY = 1'b1;
        repeat (8) send_beat(mk_marker());
        wait_drain();

        // Throughput: one beat every cycle; windows after the first partial one carry CPW beats.
        row_ignore  = 1'b1;
        AXIS_TDATA  = mk_data();
        AXIS_TVALID = 1'b1;
        w = 0;
        seen = 1'b0;
        while (!seen && w < CPW + 50) begin
            @(negedge clk);
            if (throughput_valid) seen = 1'b1;
            w++;
        end
        check_eq("tp_first_window", 72'(seen), 72'd1);
        @(posedge clk);
        #1;
        tp_q.push_back(64'(CPW * DW / 8));
        tp_q.push_back(64'(CPW * DW / 8));
        tp_chk = 1'b1;
        w = 0;
        while (tp_q.size() != 0 && w < 3 * CPW) begin
            @(negedge clk);
            w++;
        end
        check_eq("tp_windows", 72'(tp_q.size()), 72'd0);
        @(posedge clk);
        #1;
        tp_chk = 1'b0;
        idle(IDLE + 2);
        exp_row_pos = 0;
        row_ignore  = 1'b0;

        // Reset mid-row with two requests queued.
        AXI_REQ_TREADY = 1'b0;
        repeat (10) send_beat(mk_data());
        send_beat(mk_marker());
        send_beat(mk_marker());
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_comb_tready", 72'(AXIS_TREADY), 72'd0);
        check_eq("rst_comb_req_valid", 72'(AXI_REQ_TVALID), 72'd0);
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        req_q.delete();
        exp_row_pos      = 0;
        rows_since_reset = 0;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        AXI_REQ_TREADY = 1'b1;
        @(negedge clk);
        check_eq("post_rst_req_valid", 72'(AXI_REQ_TVALID), 72'd0);
        @(posedge clk);
        #1;
        repeat (RB) send_beat(mk_data());
        settle();
        check_eq("t5_row_count", 72'(row_count), 72'(exp_row_count()));

        check_eq("final_req_q", 72'(req_q.size()), 72'd0);
        check_eq("final_row_q", 72'(row_q.size()), 72'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
